// File: rtl/dmem_hs.sv
// Handshaked data memory for the skylark core: valid/ready request and response
// channels, byte/halfword/word access with extension, fixed read latency.
module dmem_hs #(
  parameter int unsigned DMEM_SIZE = 64,
  parameter int unsigned READ_LAT  = 1,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = (DMEM_SIZE > 1) ? $clog2(DMEM_SIZE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_cnt;
  logic [31:0] r_mem [DMEM_SIZE];
  logic [31:0] r_rdata;
  logic        r_err;

  logic              w_accept;
  logic [ADDR_W-1:0] w_widx;
  logic [IDX_W-1:0]  w_idx;
  logic              w_err;
  logic [31:0]       w_word;
  logic [31:0]       w_shift;
  logic [7:0]        w_lane_b;
  logic [15:0]       w_lane_h;
  logic [31:0]       w_load;
  logic [3:0]        w_be;
  logic [31:0]       w_wlane;

  assign w_accept = (r_state == S_IDLE) && req_valid;
  assign w_widx   = req_addr >> 2;
  assign w_idx    = w_widx[IDX_W-1:0];
  assign w_word   = r_mem[w_idx];

  always_comb begin
    w_err = (w_widx >= ADDR_W'(DMEM_SIZE));
    case (req_size)
      2'd1:    w_err = w_err || req_addr[0];
      2'd2:    w_err = w_err || (req_addr[1:0] != 2'b00);
      2'd3:    w_err = 1'b1;
      default: ;
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    w_shift  = w_word >> {req_addr[1:0], 3'b000};
    w_lane_b = w_shift[7:0];
    w_lane_h = req_addr[1] ? w_word[31:16] : w_word[15:0];
    case (req_size)
      2'd0:    w_load = {{24{~req_unsigned & w_lane_b[7]}}, w_lane_b};
      2'd1:    w_load = {{16{~req_unsigned & w_lane_h[15]}}, w_lane_h};
      default: w_load = w_word;
    endcase
  end

  // Store data replicated across lanes; byte enables select which land
  always_comb begin
    case (req_size)
      2'd0: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_wlane = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        w_be    = '1;
        w_wlane = req_wdata;
      end
      default: begin
        w_be    = '0;
        w_wlane = req_wdata;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem <= '{default: '0};
    end else if (w_accept && req_write && !w_err) begin
      if (w_be[0]) r_mem[w_idx][7:0]   <= w_wlane[7:0];
      if (w_be[1]) r_mem[w_idx][15:8]  <= w_wlane[15:8];
      if (w_be[2]) r_mem[w_idx][23:16] <= w_wlane[23:16];
      if (w_be[3]) r_mem[w_idx][31:24] <= w_wlane[31:24];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= 2'(READ_LAT - 1);
      r_err   <= w_err;
      r_rdata <= (w_err || req_write) ? '0 : w_load;
    end else if (r_state == S_WAIT && r_cnt != 2'd0) begin
      r_cnt <= r_cnt - 2'd1;
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = reset;
        if (req_valid) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 2'd0) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_hs.sv
// Bench for dmem_hs: byte-array reference model checked every cycle, plus
// directed literal checks for lanes, errors, reset, backpressure and spacing.
module tb_dmem_hs;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT   = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_hs #(.DMEM_SIZE(DEPTH), .READ_LAT(LAT), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: little-endian byte array
  bit [7:0]    bmem [4*DEPTH];
  logic [31:0] m_rdata;
  logic        m_err;
  bit          pend = 1'b0;
  int          acc_cyc = 0;
  int          cyc = 0;
  bit          b2b_on = 1'b0;
  int          last_acc = -1;
  bit          rnd_rdy = 1'b0;

  function automatic void model_req(input logic wr, input logic [1:0] sz, input logic uns,
                                    input logic [31:0] a, input logic [31:0] wd);
    int unsigned n;
    logic [31:0] v;
    n = 1 << sz;
    m_err = (sz == 2'd3) || (a % n != 0) || (a / 4 >= DEPTH);
    m_rdata = '0;
    if (m_err) return;
    if (wr) begin
      for (int unsigned k = 0; k < n; k++) bmem[a + k] = 8'(wd >> (8 * k));
    end else begin
      v = '0;
      for (int unsigned k = 0; k < n; k++) v = v | (32'(bmem[a + k]) << (8 * k));
      if (!uns && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      m_rdata = v;
    end
  endfunction

  always @(negedge clk) begin
    bit exp_valid;
    cyc++;
    if (!reset) begin
      pend = 1'b0;
      foreach (bmem[i]) bmem[i] = '0;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    end else begin
      exp_valid = pend && ((cyc - acc_cyc) > int'(LAT));
      chk("req_ready", 32'(req_ready), 32'(!pend));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("model_rdata", rsp_rdata, m_rdata);
        chk("model_err", 32'(rsp_err), 32'(m_err));
        if (rsp_ready) pend = 1'b0;
      end else if (!pend && req_valid) begin
        model_req(req_write, req_size, req_unsigned, req_addr, req_wdata);
        pend    = 1'b1;
        acc_cyc = cyc;
        if (b2b_on) begin
          if (last_acc >= 0) chk("accept_spacing", 32'(cyc - last_acc), 32'(LAT + 2));
          last_acc = cyc;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) rsp_ready = 1'($urandom_range(0, 1));
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (req_ready) begin
        sync();
        req_valid = 1'b0;
        return;
      end
    end
    checks++; fails++;
    $display("FAIL req_accept_timeout: req_ready stayed 0 for 60 cycles, required 1");
    req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string name, input logic [31:0] ed, input logic ee,
                            output int lat);
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      checks++; fails++;
      $display("FAIL %s_timeout: rsp_valid stayed 0 for 60 cycles, required 1", name);
    end else begin
      chk({name, "_rdata"}, rsp_rdata, ed);
      chk({name, "_err"}, 32'(rsp_err), 32'(ee));
    end
    sync();
  endtask

  initial begin
    int lat;
    logic [31:0] v_data;
    logic        v_err;
    logic [1:0]  sz, sz2;
    logic [31:0] a, a2;

    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);
    sync();

    // Reset during WAIT aborts the load
    do_req(1'b0, 2'd2, 1'b0, 32'h0, '0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    sync();
    do_req(1'b0, 2'd2, 1'b0, 32'h0, '0);
    expect_rsp("load0_after_reset", 32'h0, 1'b0, lat);

    do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF);
    expect_rsp("store_word", 32'h0, 1'b0, lat);
    do_req(1'b0, 2'd2, 1'b0, 32'h8, '0);
    expect_rsp("load_word", 32'hDEADBEEF, 1'b0, lat);
    chk("load_latency", 32'(lat), 32'(LAT + 1));

    do_req(1'b1, 2'd0, 1'b0, 32'h9, 32'h80);
    expect_rsp("store_byte", 32'h0, 1'b0, lat);
    do_req(1'b0, 2'd2, 1'b0, 32'h8, '0);
    expect_rsp("lane_word", 32'hDEAD80EF, 1'b0, lat);
    do_req(1'b0, 2'd0, 1'b0, 32'h9, '0);
    expect_rsp("lane_sbyte", 32'hFFFFFF80, 1'b0, lat);
    do_req(1'b0, 2'd0, 1'b1, 32'h9, '0);
    expect_rsp("lane_ubyte", 32'h00000080, 1'b0, lat);
    do_req(1'b0, 2'd1, 1'b0, 32'hA, '0);
    expect_rsp("lane_shalf", 32'hFFFFDEAD, 1'b0, lat);

    do_req(1'b0, 2'd2, 1'b0, 32'h6, '0);
    expect_rsp("err_misalign_word", 32'h0, 1'b1, lat);
    do_req(1'b1, 2'd2, 1'b0, 32'h0, 32'h11223344);
    expect_rsp("store_word0", 32'h0, 1'b0, lat);
    do_req(1'b1, 2'd1, 1'b0, 32'h3, 32'hFFFF);
    expect_rsp("err_misalign_half", 32'h0, 1'b1, lat);
    do_req(1'b0, 2'd2, 1'b0, 32'h0, '0);
    expect_rsp("mem_unchanged", 32'h11223344, 1'b0, lat);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, '0);
    expect_rsp("err_range", 32'h0, 1'b1, lat);
    do_req(1'b0, 2'd3, 1'b0, 32'h0, '0);
    expect_rsp("err_size3", 32'h0, 1'b1, lat);

    // Backpressure with an ignored request pulse
    rsp_ready = 1'b0;
    do_req(1'b0, 2'd2, 1'b0, 32'h8, '0);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    v_data = rsp_rdata;
    v_err  = rsp_err;
    chk("bp_first_rdata", v_data, 32'hDEAD80EF);
    for (int k = 0; k < 5; k++) begin
      sync();
      if (k == 2) begin
        req_write = 1'b1; req_size = 2'd2; req_addr = 32'h8; req_wdata = 32'h12345678;
        req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, v_data);
      chk("bp_err", 32'(rsp_err), 32'(v_err));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    sync();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_ready_next", 32'(req_ready), 32'd1);
    sync();
    do_req(1'b0, 2'd2, 1'b0, 32'h8, '0);
    expect_rsp("bp_pulse_ignored", 32'hDEAD80EF, 1'b0, lat);

    // Back-to-back store/load pairs with ready tied high
    b2b_on = 1'b1;
    last_acc = -1;
    for (int p = 0; p < 16; p++) begin
      sz  = 2'($urandom_range(0, 2));
      sz2 = 2'($urandom_range(0, 2));
      a   = 32'($urandom_range(0, DEPTH - 1)) * 4;
      a2  = a;
      if (sz == 2'd0) a = a + 32'($urandom_range(0, 3));
      if (sz == 2'd1) a = a + 32'($urandom_range(0, 1)) * 2;
      if (sz2 == 2'd0) a2 = a2 + 32'($urandom_range(0, 3));
      if (sz2 == 2'd1) a2 = a2 + 32'($urandom_range(0, 1)) * 2;
      do_req(1'b1, sz, 1'b0, a, $urandom);
      do_req(1'b0, sz2, 1'($urandom_range(0, 1)), a2, '0);
    end
    b2b_on = 1'b0;

    // Random traffic, including errors and random response backpressure
    rnd_rdy = 1'b1;
    for (int r = 0; r < 60; r++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 4 * DEPTH - 1));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end
    rnd_rdy = 1'b0;
    #2 rsp_ready = 1'b1;
    for (int i = 0; i < 100 && pend; i++) @(negedge clk);
    if (pend) begin
      checks++; fails++;
      $display("FAIL drain_timeout: response still outstanding after 100 cycles, required none");
    end
    sync();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/dmem_hs.md
Name: dmem_hs

Overview:
- Parametrised data memory for the skylark core.
- Adds to the current combinational-read dmem:
  - a valid/ready request channel and a valid/ready response channel;
  - byte, halfword and word accesses with sign/zero extension;
  - configurable read latency;
  - error reporting for misaligned and out-of-range accesses.
- Sits between the core's memory stage and the bench or SoC fabric.
- Allows one outstanding request at a time.

Parameters:
- DMEM_SIZE, 64, depth in 32-bit words; must be at least 1.
- READ_LAT, 1, cycles from request acceptance to rsp_valid; legal range 1..4.
- ADDR_W, 32, request address width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. Asserting it (0) clears all state immediately. Deassertion is synchronised externally.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  access size: 0 = byte, 1 = halfword, 2 = word, 3 = illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  ADDR_W  byte address, little-endian.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  32  load data, extended to 32 bits; 0 for stores and on error.
- rsp_err  output  1  access was misaligned, out of range or had an illegal size.

Behaviour:
- Reset (reset == 0, asynchronous):
  - FSM goes to IDLE;
  - req_ready = 0 while reset is held, then 1 in IDLE;
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0;
  - latency counter = 0;
  - all memory words = 0.
  - A reset during WAIT or RESP aborts the request; no response is ever issued for it.
- FSM states:
  - IDLE: req_ready = 1. On req_valid = 1 the request is accepted at that edge (edge N) and the FSM moves to WAIT.
  - WAIT: req_ready = 0. The counter runs from READ_LAT-1 down to 0, then the FSM moves to RESP. For READ_LAT = 1, WAIT lasts one cycle.
  - RESP: rsp_valid = 1. rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready. On that edge the FSM returns to IDLE.
- Timing:
  - rsp_valid rises at edge N+READ_LAT.
  - With rsp_ready tied high, the next request can be accepted at edge N+READ_LAT+2.
  - Outputs are registered; there is no combinational path from req_* to rsp_*.
- Error checks, evaluated at acceptance:
  - size = 1 with addr[0] != 0;
  - size = 2 with addr[1:0] != 0;
  - size = 3;
  - word index addr >> 2 >= DMEM_SIZE.
  - On error: no memory update, rsp_err = 1, rsp_rdata = 0.
- Stores:
  - committed at edge N using byte-enables derived from addr[1:0] and size;
  - bytes outside the enabled lanes are unchanged;
  - response carries rsp_rdata = 0, rsp_err = 0.
- Loads:
  - the word is read and the lane extracted at edge N, then held in a result register until the response;
  - byte lane = addr[1:0]; halfword lane = addr[1];
  - sign-extension uses the top bit of the selected lane unless req_unsigned = 1.
- Ordering: a load always observes every previously completed store (single outstanding request).
- req_* inputs are ignored outside IDLE.
- Backpressure: rsp_ready = 0 holds RESP indefinitely, with outputs stable.

Test Plan:
- Reset: hold reset = 0 for 2 cycles mid-WAIT after a load was accepted -> rsp_valid = 0, req_ready = 1 after release, and a load from addr 0x0 returns 0x00000000.
- Word store/load: store 0xDEADBEEF to 0x8, then load word from 0x8 with READ_LAT = 3 -> rsp_valid rises exactly 3 cycles after acceptance with rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Byte/halfword lanes: byte store of 0x80 to 0x9 over 0xDEADBEEF ->
  - word load returns 0xDEAD80EF;
  - signed byte load at 0x9 returns 0xFFFFFF80;
  - unsigned byte load at 0x9 returns 0x00000080;
  - signed halfword load at 0xA returns 0xFFFFDEAD.
- Errors:
  - word load at 0x6 -> rsp_err = 1, rsp_rdata = 0;
  - halfword store at 0x3 -> rsp_err = 1 and memory unchanged;
  - word load at 0x100 with DMEM_SIZE = 64 -> rsp_err = 1;
  - size = 3 -> rsp_err = 1.
- Backpressure: hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable, req_ready = 0, and a req_valid pulse during that time is ignored. After rsp_ready = 1, req_ready rises the next cycle.
- Back-to-back: 16 alternating store/load pairs to random aligned addresses with rsp_ready = 1 -> every load matches a reference model, and the spacing between accepted requests is READ_LAT+2 cycles.
